tx_burst_ctrl: RTL and testbench
================================

TX_BURST_CTRL -- requirements
Module: tx_burst_ctrl

Interface
REQ-001 Parameter PREAMBLE_LEN, default 8: preamble symbols per burst, range 1..255.
REQ-002 Parameter GAP_LEN, default 4: idle cycles after the payload, range 1..255.
REQ-003 Parameter LEN_W, default 16: width of burst_len and of the payload counter.
REQ-004 clk_clk  in  1  single clock; all logic rising-edge.
REQ-005 reset_reset_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  pulse requesting one burst.
REQ-007 burst_len  in  LEN_W  payload symbol count, sampled with start.
REQ-008 abort  in  1  terminate the current burst.
REQ-009 prbs_en  out  1  enable to the PRBS generator.
REQ-010 gray_sym_in  in  2  symbol from the gray encoder.
REQ-011 gray_sym_in_valid  in  1  gray_sym_in qualifier.
REQ-012 sym_out  out  2  symbol to the PAM encoder.
REQ-013 sym_out_valid  out  1  sym_out qualifier.
REQ-014 busy  out  1  high in any state except IDLE.
REQ-015 done  out  1  one-cycle pulse on normal completion.
REQ-016 aborted  out  1  one-cycle pulse on abort.

Function
REQ-017 The FSM SHALL have states IDLE, PREAMBLE, PAYLOAD and GAP, all registered.
REQ-018 IDLE: start=1 SHALL latch burst_len and go to PREAMBLE; start outside IDLE SHALL be ignored.
REQ-019 PREAMBLE SHALL emit PREAMBLE_LEN consecutive valid symbols alternating 2'b00, 2'b11 (starting 2'b00), then enter PAYLOAD; if the latched length is 0, it SHALL enter GAP instead.
REQ-020 prbs_en SHALL be registered, high exactly while the state is PAYLOAD.
REQ-021 PAYLOAD: each gray_sym_in_valid=1 SHALL register gray_sym_in to sym_out with sym_out_valid=1 one cycle later (latency 1) and increment the payload counter.
REQ-022 When the counter reaches the latched length, the FSM SHALL enter GAP on the next edge; no further symbols SHALL be forwarded.
REQ-023 gray_sym_in_valid outside PAYLOAD SHALL be dropped (pipeline residue), with sym_out_valid=0.
REQ-024 GAP SHALL hold sym_out_valid=0 for GAP_LEN cycles, then enter IDLE and pulse done in that same cycle.
REQ-025 abort=1 in any non-IDLE state SHALL force IDLE on the next edge and pulse aborted, with no done pulse; abort has priority over every other transition, including a simultaneous final payload symbol.
REQ-026 abort in IDLE SHALL be ignored; start and abort asserted together in IDLE SHALL start nothing.
REQ-027 sym_out SHALL hold its last value while sym_out_valid=0.

Reset
REQ-028 Reset SHALL force IDLE, clear the counters and set prbs_en, sym_out_valid, busy, done and aborted to 0 and sym_out to 2'b00.
REQ-029 Reset asserted mid-burst SHALL discard the burst; after release the block SHALL wait in IDLE for a new start.

Configuration
REQ-030 With macro TX_BURST_CTRL_PREAMBLE_EN defined, PREAMBLE SHALL behave as in REQ-019.
REQ-031 Without TX_BURST_CTRL_PREAMBLE_EN, the PREAMBLE state and counter SHALL be omitted, and start SHALL go directly to PAYLOAD (or to GAP when burst_len=0).

Structure
REQ-032 The state enum, the preamble symbol constants 2'b00 and 2'b11, and the LEN_W default SHALL live in shared package tx_ctrl_pkg.
REQ-033 The design SHALL be a single module with no sub-module; the cycle counter SHALL be shared between PREAMBLE and GAP.

Verification
REQ-034 With the macro defined, start, burst_len=4 and gray valid every cycle SHALL produce 00,11,00,11,00,11,00,11, then the 4 payload symbols, then 4 idle cycles, then done for 1 cycle.
REQ-035 burst_len=0 SHALL produce the preamble, then the GAP, then done, and prbs_en SHALL never rise.
REQ-036 burst_len=3 with gray valid on alternate cycles SHALL forward exactly 3 symbols, each 1 cycle after its input, with prbs_en dropping after the third.
REQ-037 abort in the 2nd PAYLOAD cycle SHALL give IDLE next cycle, aborted=1 for 1 cycle, done=0 and prbs_en=0.
REQ-038 start pulsed while busy SHALL give no second burst; reset mid-PAYLOAD SHALL give all outputs 0 immediately.
REQ-039 Without the macro, start with burst_len=2 SHALL give the first payload symbol with no preamble symbols.

Source files
------------

// File: rtl/tx_ctrl_pkg.sv
// rtl/tx_ctrl_pkg.sv - shared state encoding and constants for tx_burst_ctrl (PREAMBLE state only with TX_BURST_CTRL_PREAMBLE_EN)
package tx_ctrl_pkg;

  localparam int LEN_W_DEFAULT = 16;

  // Preamble alternates these two symbols, starting with the even one.
  localparam logic [1:0] PRE_SYM_EVEN = 2'b00;
  localparam logic [1:0] PRE_SYM_ODD  = 2'b11;

`ifdef TX_BURST_CTRL_PREAMBLE_EN
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_PAYLOAD  = 2'd2,
    ST_GAP      = 2'd3
  } tx_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd2,
    ST_GAP     = 2'd3
  } tx_state_t;
`endif

endpackage

// File: rtl/tx_burst_ctrl.sv
// rtl/tx_burst_ctrl.sv - burst framing FSM (optional preamble via TX_BURST_CTRL_PREAMBLE_EN)
module tx_burst_ctrl
  import tx_ctrl_pkg::*;
#(
  parameter int PREAMBLE_LEN = 8,
  parameter int GAP_LEN      = 4,
  parameter int LEN_W        = LEN_W_DEFAULT
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  input  logic             abort,
  output logic             prbs_en,
  input  logic [1:0]       gray_sym_in,
  input  logic             gray_sym_in_valid,
  output logic [1:0]       sym_out,
  output logic             sym_out_valid,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  // One cycle counter serves both PREAMBLE and GAP, so it is sized for the longer of the two.
  localparam int CNT_MAX = (PREAMBLE_LEN > GAP_LEN) ? PREAMBLE_LEN : GAP_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
`ifdef TX_BURST_CTRL_PREAMBLE_EN
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN);
`endif

  tx_state_t        state;
  logic [CNT_W-1:0] cyc_cnt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] pay_cnt;

  // Burst sequencing FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state         <= ST_IDLE;
      cyc_cnt       <= '0;
      len_q         <= '0;
      pay_cnt       <= '0;
      prbs_en       <= 1'b0;
      sym_out       <= 2'b00;
      sym_out_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      if (state != ST_IDLE && abort) begin
        // Abort wins over every other transition, including a final payload symbol.
        state         <= ST_IDLE;
        cyc_cnt       <= '0;
        pay_cnt       <= '0;
        prbs_en       <= 1'b0;
        sym_out_valid <= 1'b0;
        busy          <= 1'b0;
        aborted       <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            sym_out_valid <= 1'b0;
            if (start && !abort) begin
              len_q   <= burst_len;
              pay_cnt <= '0;
              busy    <= 1'b1;
`ifdef TX_BURST_CTRL_PREAMBLE_EN
              state         <= ST_PREAMBLE;
              sym_out       <= PRE_SYM_EVEN;
              sym_out_valid <= 1'b1;
              cyc_cnt       <= CNT_ONE;
`else
              if (burst_len == '0) begin
                state   <= ST_GAP;
                cyc_cnt <= CNT_ONE;
              end else begin
                state   <= ST_PAYLOAD;
                prbs_en <= 1'b1;
              end
`endif
            end
          end
`ifdef TX_BURST_CTRL_PREAMBLE_EN
          ST_PREAMBLE: begin
            if (cyc_cnt == PRE_LAST) begin
              sym_out_valid <= 1'b0;
              if (len_q == '0) begin
                state   <= ST_GAP;
                cyc_cnt <= CNT_ONE;
              end else begin
                state   <= ST_PAYLOAD;
                prbs_en <= 1'b1;
                cyc_cnt <= '0;
              end
            end else begin
              // cyc_cnt is the index of the next preamble symbol.
              sym_out       <= cyc_cnt[0] ? PRE_SYM_ODD : PRE_SYM_EVEN;
              sym_out_valid <= 1'b1;
              cyc_cnt       <= cyc_cnt + 1'b1;
            end
          end
`endif
          ST_PAYLOAD: begin
            if (pay_cnt == len_q) begin
              state         <= ST_GAP;
              prbs_en       <= 1'b0;
              sym_out_valid <= 1'b0;
              cyc_cnt       <= CNT_ONE;
            end else if (gray_sym_in_valid) begin
              sym_out       <= gray_sym_in;
              sym_out_valid <= 1'b1;
              pay_cnt       <= pay_cnt + 1'b1;
            end else begin
              sym_out_valid <= 1'b0;
            end
          end
          ST_GAP: begin
            sym_out_valid <= 1'b0;
            if (cyc_cnt == GAP_LAST) begin
              state   <= ST_IDLE;
              cyc_cnt <= '0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              cyc_cnt <= cyc_cnt + 1'b1;
            end
          end
          default: begin
            state         <= ST_IDLE;
            prbs_en       <= 1'b0;
            sym_out_valid <= 1'b0;
            busy          <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tx_burst_ctrl.sv
// tb/tb_tx_burst_ctrl.sv - scoreboard bench for tx_burst_ctrl
module tb_tx_burst_ctrl;

  localparam int PL = 8;
  localparam int GL = 4;
  localparam int LW = 16;
`ifdef TX_BURST_CTRL_PREAMBLE_EN
  localparam int PRE = PL;
`else
  localparam int PRE = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] blen = '0;
  logic          abort = 1'b0;
  logic [1:0]    gsym = 2'b00;
  logic          gvalid = 1'b0;
  logic          prbs_en;
  logic [1:0]    sym_out;
  logic          sym_out_valid;
  logic          busy;
  logic          done;
  logic          aborted;

  tx_burst_ctrl #(.PREAMBLE_LEN(PL), .GAP_LEN(GL), .LEN_W(LW)) dut (
    .clk_clk(clk),
    .reset_reset_n(rst_n),
    .start(start),
    .burst_len(blen),
    .abort(abort),
    .prbs_en(prbs_en),
    .gray_sym_in(gsym),
    .gray_sym_in_valid(gvalid),
    .sym_out(sym_out),
    .sym_out_valid(sym_out_valid),
    .busy(busy),
    .done(done),
    .aborted(aborted)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [1:0] sym; int cyc; } sym_exp_t;
  typedef struct { logic is_done; int cyc; } ev_exp_t;
  sym_exp_t sq[$];
  ev_exp_t  eq[$];
  sym_exp_t se;
  ev_exp_t  ee;

  int checks = 0;
  int errors = 0;
  bit prbs_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a symbol or a pulse.
  always @(negedge clk) begin
    if (prbs_en) prbs_seen = 1'b1;
    if (rst_n) begin
      if (sym_out_valid) begin
        if (sq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_sym: got sym %0d with nothing expected (cycle %0d)", sym_out, cyc);
        end else begin
          se = sq.pop_front();
          check("sym_val", sym_out, se.sym);
          check("sym_cyc", cyc, se.cyc);
        end
      end
      if (done || aborted) begin
        if (eq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pulse: got done=%0d aborted=%0d with nothing expected (cycle %0d)", done, aborted, cyc);
        end else begin
          ee = eq.pop_front();
          check("pulse_kind_done", done, ee.is_done);
          check("pulse_kind_abort", aborted, !ee.is_done);
          check("pulse_cyc", cyc, ee.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues start; returns in the first cycle after any preamble.
  task automatic do_start(input int len);
    int c;
    logic [1:0] ps;
    c = cyc;
    start = 1'b1;
    blen = LW'(len);
    tick();
    start = 1'b0;
    for (int k = 0; k < PRE; k++) begin
      ps = (k % 2 == 1) ? 2'b11 : 2'b00;
      sq.push_back('{sym: ps, cyc: c + 1 + k});
    end
    repeat (PRE) tick();
  endtask

  task automatic send(input logic [1:0] s);
    gvalid = 1'b1;
    gsym = s;
    sq.push_back('{sym: s, cyc: cyc + 1});
    tick();
    gvalid = 1'b0;
  endtask

  task automatic junk(input logic [1:0] s);
    gvalid = 1'b1;
    gsym = s;
    tick();
    gvalid = 1'b0;
  endtask

  initial begin
    int c0;
    int lc;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int lc;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {busy, prbs_en, sym_out_valid, done, aborted, sym_out}, 0);
    rst_n = 1'b1;
    tick();
    check("idle_busy", busy, 0);

    // Four payload symbols, gray valid every cycle.
    do_start(4);
    send(2'b01); send(2'b10); send(2'b11); send(2'b01);
    lc = cyc;
    check("prbs_last_payload", prbs_en, 1);
    eq.push_back('{is_done: 1'b1, cyc: lc + 1 + GL});
    junk(2'b10);
    check("prbs_after_payload", prbs_en, 0);
    check("sym_hold", sym_out, 2'b01);
    junk(2'b10);
    repeat (GL + 2) tick();
    check("busy_after_done", busy, 0);

    // Zero-length burst: no payload, prbs_en never rises.
    prbs_seen = 1'b0;
    c0 = cyc;
    eq.push_back('{is_done: 1'b1, cyc: c0 + 1 + PRE + GL});
    do_start(0);
    junk(2'b11);
    repeat (GL + 2) tick();
    check("len0_prbs_never", prbs_seen, 0);
    check("len0_busy", busy, 0);

    // Three symbols on alternate cycles.
    do_start(3);
    send(2'b10); tick(); send(2'b00); tick(); send(2'b11);
    lc = cyc;
    check("alt_prbs_hi", prbs_en, 1);
    eq.push_back('{is_done: 1'b1, cyc: lc + 1 + GL});
    tick();
    check("alt_prbs_lo", prbs_en, 0);
    repeat (GL + 2) tick();

    // Abort in the second payload cycle.
    do_start(5);
    send(2'b11);
    abort = 1'b1;
    eq.push_back('{is_done: 1'b0, cyc: cyc + 1});
    junk(2'b01);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_prbs", prbs_en, 0);
    check("abort_valid", sym_out_valid, 0);
    repeat (GL + 3) tick();

    // Abort together with the final payload symbol.
    do_start(1);
    abort = 1'b1;
    eq.push_back('{is_done: 1'b0, cyc: cyc + 1});
    junk(2'b10);
    abort = 1'b0;
    check("abort_final_valid", sym_out_valid, 0);
    repeat (GL + 3) tick();

    // Start with abort in IDLE, and abort alone in IDLE.
    start = 1'b1; abort = 1'b1; blen = LW'(2);
    tick();
    start = 1'b0;
    check("start_abort_idle", busy, 0);
    tick();
    abort = 1'b0;
    check("abort_idle_busy", busy, 0);
    tick();

    // Start while busy is ignored.
    do_start(2);
    send(2'b10);
    start = 1'b1; blen = LW'(1);
    send(2'b01);
    start = 1'b0;
    lc = cyc;
    eq.push_back('{is_done: 1'b1, cyc: lc + 1 + GL});
    repeat (GL + 4) tick();
    check("no_second_burst", busy, 0);

    // Reset mid-payload.
    do_start(6);
    send(2'b01); send(2'b10);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_outputs", {busy, prbs_en, sym_out_valid, done, aborted, sym_out}, 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("post_reset_busy", busy, 0);

    // Recovery burst after reset.
    do_start(1);
    send(2'b11);
    lc = cyc;
    eq.push_back('{is_done: 1'b1, cyc: lc + 1 + GL});
    repeat (GL + 3) tick();

    check("sym_queue_empty", sq.size(), 0);
    check("pulse_queue_empty", eq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
